jtvigil_obj_rom_slot: RTL and testbench
=======================================

// Module: jtvigil_obj_rom_slot
// PURPOSE
//  Memory-side responder for the object engine's ROM port (rom_cs/rom_addr/rom_ok/rom_data).
//  Converts each 32-bit object ROM read into a two-beat 16-bit SDRAM read and caches the last line.
//  Holds rom_ok only while the presented address matches the cached one.
//  Sits between the object engine and the SDRAM bank arbiter in the game top level.
// PARAMETERS
//  OFFSET   22'h0   SDRAM word offset of the object ROM region
//  AW       18      object ROM word address width (16-bit words)
// PORTS
//  rst        in   1   asynchronous reset, active high
//  clk        in   1   system clock, same as object engine
//  rom_cs     in   1   object engine request active
//  rom_addr   in   AW  16-bit word address; bit 0 always 0 (32-bit aligned)
//  rom_ok     out  1   rom_data valid for current rom_addr
//  rom_data   out  32  {word addr+1, word addr}
//  sdram_req  out  1   SDRAM read request, held until ack
//  sdram_addr out  22  OFFSET + {rom_addr[AW-1:1],1'b0}
//  sdram_ack  in   1   arbiter accepted request (1-cycle pulse)
//  data_dst   in   1   data beat strobe, one per 16-bit word
//  data_rdy   in   1   last beat of burst
//  data_read  in   16  SDRAM read data
// BEHAVIOUR
//  Reset: rom_ok=0, rom_data=0, sdram_req=0, sdram_addr=0, cache invalid, FSM=IDLE.
//  Cache: one line; tag = rom_addr[AW-1:1]; valid bit.
//  rom_ok = rom_cs & valid & (tag==rom_addr[AW-1:1]) & state==IDLE; combinational on address,
//    so an address change drops rom_ok in the same cycle (engine registers rom_ok).
//  FSM:
//   IDLE: rom_cs & !hit -> latch addr, sdram_req=1, valid=0 -> REQ. Else stay.
//   REQ : sdram_req held high; on sdram_ack -> sdram_req=0 -> BEAT0.
//   BEAT0: on data_dst -> rom_data[15:0]=data_read -> BEAT1.
//   BEAT1: on data_dst -> rom_data[31:16]=data_read; valid=1 -> IDLE.
//     data_rdy with data_dst in BEAT1 is the normal end; data_rdy in BEAT0 is a protocol
//     error: abandon the burst, stay invalid, return to IDLE (re-request next cycle).
//  Latency: miss with ack on cycle 1 after request and beats on consecutive cycles -> rom_ok
//    high 1 cycle after second beat; hit -> rom_ok same cycle as address presented.
//  Address changes during REQ/BEAT*: fetch completes for the latched address, cache fills, then
//    IDLE compares; on mismatch a new request starts the next cycle (never cancel mid-burst).
//  rom_cs low during a fetch: fetch completes and fills cache; rom_ok stays low while rom_cs low.
//  sdram_ack and data_dst in same cycle (zero-latency arbiter): handle both; enter BEAT1 directly.
//  Tag wrap: address 0x3FFFE -> words 0x3FFFE,0x3FFFF; no carry into OFFSET beyond 22 bits.
//  Reset mid-burst: immediate IDLE, invalid; late beats from arbiter ignored in IDLE.
//  Must cover the engine's pattern: second half read toggles rom_addr[1] right after rom_ok.
// STRUCTURE
//  Single module, no sub-modules. FSM state encoding as localparams in this file; OFFSET width
//  and the SDRAM slot interface widths belong in the shared jtvigil package constants
//  (shared with the scroll and character ROM slots).
// TESTING
//  Miss: rst, rom_cs=1, addr=0x00124, ack at +2, beats 0xA1B2,0xC3D4 -> sdram_addr=OFFSET+0x124,
//    rom_data=32'hC3D4_A1B2, rom_ok=1 next cycle.
//  Hit: same addr re-presented after rom_cs low -> rom_ok=1 same cycle, no sdram_req.
//  Half toggle: rom_ok on 0x00124, then addr=0x00126 -> rom_ok=0 that cycle, new req to 0x126.
//  Mid-burst change: addr moves 0x100->0x200 during BEAT0 -> 0x100 completes, then req 0x200;
//    rom_ok never high with 0x100 data while addr=0x200.
//  Zero-latency arbiter: ack and first dst same cycle, second dst next -> correct 32-bit word.
//  Reset mid-burst: rst during BEAT1, then stray data_dst -> rom_ok=0, sdram_req=0, no fill.

Source files
------------

// File: rtl/jtvigil_obj_rom_slot_pkg.sv
// Shared jtvigil ROM-slot constants: SDRAM slot interface widths and object ROM data width.
// The scroll and character ROM slots use the same values.
package jtvigil_obj_rom_slot_pkg;

   localparam int SDRAM_AW = 22;
   localparam int SDRAM_DW = 16;
   localparam int ROM_DW   = 32;

endpackage

// File: rtl/jtvigil_obj_rom_slot.sv
// Object ROM slot: serves 32-bit object engine reads from a one-line cache that is
// refilled by two-beat 16-bit SDRAM bursts.
module jtvigil_obj_rom_slot
   import jtvigil_obj_rom_slot_pkg::*;
#(
   parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0,
   parameter int                  AW     = 18
) (
   input  logic                rst,
   input  logic                clk,
   input  logic                rom_cs,
   input  logic [AW-1:0]       rom_addr,
   output logic                rom_ok,
   output logic [ROM_DW-1:0]   rom_data,
   output logic                sdram_req,
   output logic [SDRAM_AW-1:0] sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_dst,
   input  logic                data_rdy,
   input  logic [SDRAM_DW-1:0] data_read
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_BEAT0 = 2'd2;
   localparam logic [1:0] ST_BEAT1 = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      REQ   = ST_REQ,
      BEAT0 = ST_BEAT0,
      BEAT1 = ST_BEAT1
   } state_t;

   state_t              state_q, state_d;
   logic                valid_q, valid_d;
   logic [AW-2:0]       tag_q, tag_d;
   logic [ROM_DW-1:0]   rom_data_q, rom_data_d;
   logic                sdram_req_q, sdram_req_d;
   logic [SDRAM_AW-1:0] sdram_addr_q, sdram_addr_d;
   logic                hit;
   logic                unused_addr_lsb;

   // Word address bit 0 is always zero for 32-bit aligned reads.
   assign unused_addr_lsb = rom_addr[0];

   assign hit        = valid_q && (tag_q == rom_addr[AW-1:1]);
   assign rom_ok     = rom_cs && hit && (state_q == IDLE);
   assign rom_data   = rom_data_q;
   assign sdram_req  = sdram_req_q;
   assign sdram_addr = sdram_addr_q;

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      rom_data_d   = rom_data_q;
      sdram_req_d  = sdram_req_q;
      sdram_addr_d = sdram_addr_q;
      case (state_q)
         IDLE: begin
            if (rom_cs && !hit) begin
               tag_d        = rom_addr[AW-1:1];
               valid_d      = 1'b0;
               sdram_req_d  = 1'b1;
               sdram_addr_d = OFFSET + SDRAM_AW'({rom_addr[AW-1:1], 1'b0});
               state_d      = REQ;
            end
         end
         // A zero-latency arbiter may deliver the first beat together with the ack.
         REQ: begin
            if (sdram_ack) begin
               sdram_req_d = 1'b0;
               if (data_rdy) begin
                  state_d = IDLE;
               end else if (data_dst) begin
                  rom_data_d[SDRAM_DW-1:0] = data_read;
                  state_d                  = BEAT1;
               end else begin
                  state_d = BEAT0;
               end
            end
         end
         // A burst ending before its second beat is abandoned; the line stays invalid.
         BEAT0: begin
            if (data_rdy) begin
               state_d = IDLE;
            end else if (data_dst) begin
               rom_data_d[SDRAM_DW-1:0] = data_read;
               state_d                  = BEAT1;
            end
         end
         BEAT1: begin
            if (data_dst) begin
               rom_data_d[ROM_DW-1:SDRAM_DW] = data_read;
               valid_d                       = 1'b1;
               state_d                       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         valid_q      <= 1'b0;
         tag_q        <= '0;
         rom_data_q   <= '0;
         sdram_req_q  <= 1'b0;
         sdram_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         tag_q        <= tag_d;
         rom_data_q   <= rom_data_d;
         sdram_req_q  <= sdram_req_d;
         sdram_addr_q <= sdram_addr_d;
      end
   end

endmodule

// File: tb/tb_jtvigil_obj_rom_slot.sv
// Bench for jtvigil_obj_rom_slot: directed arbiter sequences plus a cache-level reference
// model compared against the DUT on every falling edge.
module tb_jtvigil_obj_rom_slot;

   localparam logic [21:0] OFFS = 22'h3F0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rom_cs = 1'b0;
   logic [17:0] rom_addr = '0;
   logic        sdram_ack = 1'b0;
   logic        data_dst = 1'b0;
   logic        data_rdy = 1'b0;
   logic [15:0] data_read = '0;
   logic        rom_ok;
   logic [31:0] rom_data;
   logic        sdram_req;
   logic [21:0] sdram_addr;

   int n_cmp = 0;
   int n_bad = 0;

   jtvigil_obj_rom_slot #(.OFFSET(OFFS), .AW(18)) dut (
      .rst       (rst),
      .clk       (clk),
      .rom_cs    (rom_cs),
      .rom_addr  (rom_addr),
      .rom_ok    (rom_ok),
      .rom_data  (rom_data),
      .sdram_req (sdram_req),
      .sdram_addr(sdram_addr),
      .sdram_ack (sdram_ack),
      .data_dst  (data_dst),
      .data_rdy  (data_rdy),
      .data_read (data_read)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: line contents, a pending fetch, and how far the burst has got.
   bit          m_valid, m_busy, m_acked, m_beat, e_ok, e_req;
   logic [16:0] m_tag, m_pend;
   logic [15:0] m_lo;
   logic [31:0] m_data;
   logic [21:0] e_addr;

   initial begin
      m_valid = 0; m_busy = 0; m_acked = 0; m_beat = 0;
      m_tag = '0; m_pend = '0; m_lo = '0; m_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            checkOutput("rst_rom_ok", rom_ok, 0);
            checkOutput("rst_sdram_req", sdram_req, 0);
            checkOutput("rst_sdram_addr", sdram_addr, 0);
            checkOutput("rst_rom_data", rom_data, 0);
            m_valid = 0; m_busy = 0; m_acked = 0; m_beat = 0;
         end else begin
            e_ok  = rom_cs && m_valid && (m_tag == rom_addr[17:1]) && !m_busy;
            e_req = m_busy && !m_acked;
            checkOutput("model_rom_ok", rom_ok, e_ok);
            if (e_ok) checkOutput("model_rom_data", rom_data, m_data);
            checkOutput("model_sdram_req", sdram_req, e_req);
            if (e_req) begin
               e_addr = 22'((32'(OFFS) + 32'(m_pend) * 2) & 32'h3FFFFF);
               checkOutput("model_sdram_addr", sdram_addr, e_addr);
            end
            if (m_busy) begin
               if (!m_acked && sdram_ack) m_acked = 1;
               if (m_acked && !m_beat && data_rdy) begin
                  m_busy = 0;
               end else if (m_acked && data_dst) begin
                  if (!m_beat) begin
                     m_lo   = data_read;
                     m_beat = 1;
                  end else begin
                     m_data  = {data_read, m_lo};
                     m_tag   = m_pend;
                     m_valid = 1;
                     m_busy  = 0;
                  end
               end
            end else if (rom_cs && !(m_valid && m_tag == rom_addr[17:1])) begin
               m_busy  = 1;
               m_acked = 0;
               m_beat  = 0;
               m_valid = 0;
               m_pend  = rom_addr[17:1];
            end
         end
      end
   end

   task automatic waitReq();
      int n = 0;
      while (!sdram_req && n < 20) begin
         tick();
         n++;
      end
      if (!sdram_req) checkOutput("req_timeout", 32'(sdram_req), 1);
   endtask

   // Plays the arbiter for one burst: ack after ackDelay cycles, then two beats.
   task automatic applyStimulus(input int ackDelay, input logic [15:0] d0, input logic [15:0] d1,
                                input bit zeroLat, input logic [21:0] expAddr);
      waitReq();
      checkOutput("fetch_sdram_addr", sdram_addr, expAddr);
      repeat (ackDelay) tick();
      sdram_ack = 1;
      if (zeroLat) begin
         data_dst  = 1;
         data_read = d0;
      end
      tick();
      sdram_ack = 0;
      if (!zeroLat) begin
         data_dst  = 1;
         data_read = d0;
         tick();
      end
      data_dst  = 1;
      data_rdy  = 1;
      data_read = d1;
      tick();
      data_dst = 0;
      data_rdy = 0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      @(negedge clk);
      checkOutput("reset_rom_data", rom_data, 0);
      tick();
      rst = 0;

      // Miss on 0x124, ack two cycles after the request
      rom_cs   = 1;
      rom_addr = 18'h00124;
      applyStimulus(2, 16'hA1B2, 16'hC3D4, 0, 22'h3F0124);
      @(negedge clk);
      checkOutput("miss_rom_ok", rom_ok, 1);
      checkOutput("miss_rom_data", rom_data, 32'hC3D4A1B2);

      // Hit after rom_cs drops and returns
      tick();
      rom_cs = 0;
      tick();
      rom_cs = 1;
      @(negedge clk);
      checkOutput("hit_rom_ok", rom_ok, 1);
      checkOutput("hit_no_req", sdram_req, 0);

      // Engine's second-half read
      tick();
      rom_addr = 18'h00126;
      @(negedge clk);
      checkOutput("half_rom_ok_drop", rom_ok, 0);
      applyStimulus(1, 16'h1111, 16'h2222, 0, 22'h3F0126);
      @(negedge clk);
      checkOutput("half_rom_data", rom_data, 32'h22221111);

      // Address moves during BEAT0; old fetch completes before the new request
      tick();
      rom_addr = 18'h00100;
      waitReq();
      checkOutput("mid_sdram_addr0", sdram_addr, 22'h3F0100);
      sdram_ack = 1;
      tick();
      sdram_ack = 0;
      rom_addr  = 18'h00200;
      data_dst  = 1;
      data_read = 16'h0100;
      tick();
      data_read = 16'h0101;
      data_rdy  = 1;
      tick();
      data_dst = 0;
      data_rdy = 0;
      @(negedge clk);
      checkOutput("mid_rom_ok_stale", rom_ok, 0);
      applyStimulus(1, 16'h0200, 16'h0201, 0, 22'h3F0200);
      @(negedge clk);
      checkOutput("mid_rom_data", rom_data, 32'h02010200);

      // Zero-latency arbiter
      tick();
      rom_addr = 18'h03000;
      applyStimulus(0, 16'hBEEF, 16'hCAFE, 1, 22'h3F3000);
      @(negedge clk);
      checkOutput("zl_rom_ok", rom_ok, 1);
      checkOutput("zl_rom_data", rom_data, 32'hCAFEBEEF);

      // Burst ends on its first beat: abandoned, then re-requested
      tick();
      rom_addr = 18'h00400;
      waitReq();
      sdram_ack = 1;
      tick();
      sdram_ack = 0;
      data_dst  = 1;
      data_rdy  = 1;
      data_read = 16'hDEAD;
      tick();
      data_dst = 0;
      data_rdy = 0;
      @(negedge clk);
      checkOutput("abort_rom_ok", rom_ok, 0);
      applyStimulus(1, 16'h4000, 16'h4001, 0, 22'h3F0400);
      @(negedge clk);
      checkOutput("abort_rom_data", rom_data, 32'h40014000);

      // Top of the ROM: offset addition drops the carry out of 22 bits
      tick();
      rom_addr = 18'h3FFFE;
      applyStimulus(1, 16'h7E7E, 16'h7F7F, 0, 22'h02FFFE);
      @(negedge clk);
      checkOutput("wrap_rom_ok", rom_ok, 1);
      checkOutput("wrap_rom_data", rom_data, 32'h7F7F7E7E);

      // Reset during BEAT1 followed by a stray beat
      tick();
      rom_addr = 18'h00800;
      waitReq();
      sdram_ack = 1;
      tick();
      sdram_ack = 0;
      data_dst  = 1;
      data_read = 16'h5555;
      tick();
      data_dst = 0;
      rom_cs   = 0;
      rst      = 1;
      tick();
      rst       = 0;
      data_dst  = 1;
      data_rdy  = 1;
      data_read = 16'h6666;
      tick();
      data_dst = 0;
      data_rdy = 0;
      @(negedge clk);
      checkOutput("rstmid_sdram_req", sdram_req, 0);
      checkOutput("rstmid_rom_data", rom_data, 0);
      tick();
      rom_cs = 1;
      @(negedge clk);
      checkOutput("rstmid_no_fill", rom_ok, 0);
      applyStimulus(1, 16'h8080, 16'h8181, 0, 22'h3F0800);
      @(negedge clk);
      checkOutput("rstmid_refill_data", rom_data, 32'h81818080);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
